// File: rtl/uart_cmd_decoder_if.sv
// RX FIFO pop handshake between the command decoder (master) and the UART RX FIFO (slave).
// With UART_CMD_ECHO_EN defined the bundle also carries the TX FIFO push used for echo.
interface uart_cmd_decoder_if;
  logic       rx_empty;
  logic [7:0] rx_fifo_data;
  logic       rx_rd;
`ifdef UART_CMD_ECHO_EN
  logic       tx_full;
  logic       tx_push;
  logic [7:0] tx_data;

  modport master (input rx_empty, rx_fifo_data, tx_full, output rx_rd, tx_push, tx_data);
  modport slave  (output rx_empty, rx_fifo_data, tx_full, input rx_rd, tx_push, tx_data);
`else
  modport master (input rx_empty, rx_fifo_data, output rx_rd);
  modport slave  (output rx_empty, rx_fifo_data, input rx_rd);
`endif
endinterface

// File: rtl/uart_cmd_decoder.sv
// Pops ASCII bytes from the UART RX FIFO and turns them into watch/stopwatch pulse and level commands.
// Define UART_CMD_ECHO_EN to echo each recognised command byte back through the TX FIFO.
module uart_cmd_decoder #(
  parameter int FIFO_RD_LAT = 1,
  parameter int ERR_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  uart_cmd_decoder_if.master fifo,
  output logic               cmd_r,
  output logic               cmd_c,
  output logic               cmd_H,
  output logic               cmd_M,
  output logic               cmd_S,
  output logic               cmd_m,
  output logic               cmd_s,
  output logic               cmd_L,
  output logic [ERR_W-1:0]   err_cnt,
  output logic               busy
);

  localparam logic [7:0] CHR_R  = 8'h72;
  localparam logic [7:0] CHR_C  = 8'h63;
  localparam logic [7:0] CHR_HU = 8'h48;
  localparam logic [7:0] CHR_MU = 8'h4D;
  localparam logic [7:0] CHR_SU = 8'h53;
  localparam logic [7:0] CHR_ML = 8'h6D;
  localparam logic [7:0] CHR_SL = 8'h73;
  localparam logic [7:0] CHR_L  = 8'h4C;
  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;

`ifdef UART_CMD_ECHO_EN
  typedef enum logic [1:0] {IDLE, WAIT, DECODE, ECHO} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT, DECODE} state_t;
`endif

  state_t     state;
  state_t     next_state;
  logic [1:0] wait_cnt;
  logic [7:0] byte_q;
  logic       pop;
  logic       latch;
  logic       decode;

`ifdef UART_CMD_ECHO_EN
  logic       push;
  logic       tx_push_q;
  logic [7:0] tx_data_q;

  function automatic logic is_cmd(input logic [7:0] b);
    case (b)
      CHR_R, CHR_C, CHR_HU, CHR_MU, CHR_SU, CHR_ML, CHR_SL, CHR_L: is_cmd = 1'b1;
      default:                                                    is_cmd = 1'b0;
    endcase
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (!fifo.rx_empty) next_state = WAIT;
      WAIT:    if (wait_cnt == 2'd1) next_state = DECODE;
`ifdef UART_CMD_ECHO_EN
      DECODE:  next_state = is_cmd(byte_q) ? ECHO : IDLE;
      ECHO:    if (!fifo.tx_full) next_state = IDLE;
`else
      DECODE:  next_state = IDLE;
`endif
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    pop    = 1'b0;
    latch  = 1'b0;
    decode = 1'b0;
`ifdef UART_CMD_ECHO_EN
    push   = 1'b0;
`endif
    case (state)
      IDLE:    pop    = !fifo.rx_empty;
      WAIT:    latch  = (wait_cnt == 2'd1);
      DECODE:  decode = 1'b1;
`ifdef UART_CMD_ECHO_EN
      ECHO:    push   = !fifo.tx_full;
`endif
      default: ;
    endcase
  end

  // Gated by rst so the FIFO is never popped while the decoder is held in reset.
  assign fifo.rx_rd = pop & ~rst;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 2'd0;
      byte_q   <= 8'h00;
    end else begin
      if (pop)                 wait_cnt <= 2'(FIFO_RD_LAT);
      else if (state == WAIT)  wait_cnt <= wait_cnt - 2'd1;
      if (latch)               byte_q   <= fifo.rx_fifo_data;
    end
  end

  // Pulses are decoded straight off the FIFO data so the flops are high during the DECODE cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_r <= 1'b0;
      cmd_c <= 1'b0;
      cmd_H <= 1'b0;
      cmd_M <= 1'b0;
      cmd_S <= 1'b0;
    end else begin
      cmd_r <= latch && (fifo.rx_fifo_data == CHR_R);
      cmd_c <= latch && (fifo.rx_fifo_data == CHR_C);
      cmd_H <= latch && (fifo.rx_fifo_data == CHR_HU);
      cmd_M <= latch && (fifo.rx_fifo_data == CHR_MU);
      cmd_S <= latch && (fifo.rx_fifo_data == CHR_SU);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_m   <= 1'b0;
      cmd_s   <= 1'b0;
      cmd_L   <= 1'b0;
      err_cnt <= '0;
    end else if (decode) begin
      case (byte_q)
        CHR_ML:                               cmd_m <= ~cmd_m;
        CHR_SL:                               cmd_s <= ~cmd_s;
        CHR_L:                                cmd_L <= ~cmd_L;
        CHR_R, CHR_C, CHR_HU, CHR_MU, CHR_SU,
        CHR_CR, CHR_LF:                       ;
        default: if (err_cnt != '1)           err_cnt <= err_cnt + ERR_W'(1);
      endcase
    end
  end

`ifdef UART_CMD_ECHO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_push_q <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      tx_push_q <= push;
      if (push) tx_data_q <= byte_q;
    end
  end

  assign fifo.tx_push = tx_push_q;
  assign fifo.tx_data = tx_data_q;
`endif

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Controller that sequences UART command traffic into the watch/stopwatch top level.
- Pops bytes from the RX FIFO, decodes single ASCII characters and drives the top level's command inputs.
- Pulse commands: cmd_r, cmd_c, cmd_H, cmd_M, cmd_S, each a 1-cycle pulse.
- Level commands: cmd_m, cmd_s, cmd_L, each a toggled level.
- Sits between the UART RX FIFO and the watch top level; one instance per design.

Parameters:
- FIFO_RD_LAT, 1, cycles from rx_rd pulse to valid rx_fifo_data; legal values 1 or 2.
- ERR_W, 8, width of the unknown-byte counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_empty  in  1  RX FIFO empty flag
- rx_fifo_data  in  8  RX FIFO read data
- rx_rd  out  1  FIFO pop strobe, 1 cycle
- cmd_r  out  1  pulse: 'r' (0x72)
- cmd_c  out  1  pulse: 'c' (0x63)
- cmd_H  out  1  pulse: 'H' (0x48)
- cmd_M  out  1  pulse: 'M' (0x4D)
- cmd_S  out  1  pulse: 'S' (0x53)
- cmd_m  out  1  level, toggled by 'm' (0x6D)
- cmd_s  out  1  level, toggled by 's' (0x73)
- cmd_L  out  1  level, toggled by 'L' (0x4C)
- err_cnt  out  ERR_W  saturating count of unrecognised bytes
- busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, FSM to IDLE, byte register cleared, wait counter cleared.
- IDLE: if rx_empty==0, assert rx_rd for exactly 1 cycle, load wait counter with FIFO_RD_LAT, go WAIT. Otherwise stay.
- WAIT: decrement counter. When it reaches 0, latch rx_fifo_data into the byte register and go DECODE. rx_empty is ignored in WAIT; the popped byte is always consumed.
- DECODE (1 cycle): act on the latched byte, then go IDLE.
  - 'r', 'c', 'H', 'M', 'S': assert the matching pulse output for this cycle only.
  - 'm', 's', 'L': invert the matching level output at the end of this cycle.
  - 0x0D, 0x0A: no action, err_cnt unchanged.
  - Any other byte: err_cnt += 1, saturating at all-ones (no wrap).
- All cmd outputs are registered. At most one pulse output is high in any cycle, and pulses never span 2 cycles.
- Latency with FIFO_RD_LAT=1: rx_rd in cycle N, data latched at end of N+1, pulse or toggle in N+2, next rx_rd earliest in N+3.
- Throughput: one byte per FIFO_RD_LAT+2 cycles.
- Never issues rx_rd while busy (no back-to-back pops), so the FIFO cannot underflow.
- Case sensitive: 'h', 'R' etc. count as errors.
- Reset mid-operation: an in-flight byte already popped is discarded, level commands return to 0, no pulse is emitted.
- Bytes arriving while busy wait in the FIFO; no loss.

Optional Feature:
- Macro: UART_CMD_ECHO_EN.
- Defined:
  - Adds ports tx_full (in, 1), tx_push (out, 1), tx_data (out, 8).
  - After DECODE of a recognised command byte (the 8 listed characters only), FSM enters ECHO.
  - ECHO waits while tx_full==1, then asserts tx_push for 1 cycle with tx_data = that byte, then goes IDLE.
  - CR/LF and unknown bytes are not echoed and go straight to IDLE.
  - tx_push and tx_data reset to 0; reset during ECHO drops the echo.
- Not defined: no tx ports, no ECHO state, DECODE always returns to IDLE.

Test Plan:
- Reset release, rx_empty=1 for 20 cycles -> rx_rd never asserted, all outputs 0, busy=0.
- FIFO holds 0x72, FIFO_RD_LAT=1 -> rx_rd at cycle N, cmd_r=1 only in N+2, next rx_rd no earlier than N+3.
- Bytes 'm', 'm', 'L' -> cmd_m 0→1→0, cmd_L ends at 1, no pulse outputs ever asserted.
- Bytes 0x0D, 0x0A, 'x', 'h' -> err_cnt = 2, no cmd activity.
- 300 unknown bytes with ERR_W=8 -> err_cnt saturates at 255.
- rst asserted during WAIT after popping 'H' -> cmd_H never pulses, outputs 0, FSM resumes from IDLE on the next byte.
- With UART_CMD_ECHO_EN: byte 'S', tx_full=1 for 5 cycles -> cmd_S pulses, tx_push held off, then a single tx_push with tx_data=0x53 in the cycle after tx_full drops.
